// File: rtl/argmax_stream.sv
// argmax_stream: streaming FP32 arg-max stage.
//   Consumes a frame of IEEE-754 single-precision words and emits a two-word
//   result frame: word0 = {len_err, all_nan, zeros, index}, word1 = max value.
//   Ordering uses a sign-magnitude to unsigned key transform, so no FP core is
//   needed. NaNs never participate in the compare.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   INPUT_AXIS_*        FP32 element stream in (TDATA/TLAST/TVALID/TREADY)
//   OUTPUT_AXIS_*       result stream out (TLAST marks word1)
module argmax_stream #(
  parameter int LEN   = 4,
  parameter int IDX_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] INPUT_AXIS_TDATA,
  input  logic        INPUT_AXIS_TLAST,
  input  logic        INPUT_AXIS_TVALID,
  output logic        INPUT_AXIS_TREADY,
  output logic [31:0] OUTPUT_AXIS_TDATA,
  output logic        OUTPUT_AXIS_TLAST,
  output logic        OUTPUT_AXIS_TVALID,
  input  logic        OUTPUT_AXIS_TREADY
);

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(LEN - 1);

  typedef enum logic [1:0] {S_ACCUM, S_IDX, S_VAL} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_count;
  logic [31:0]      r_best_key;
  logic [IDX_W-1:0] r_best_idx;
  logic [31:0]      r_best_val;
  logic             r_have;      // a non-NaN element has been held this frame
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_out_last;
  logic [31:0]      r_out_data;

  logic             w_in_beat;
  logic             w_out_beat;
  logic             w_nan;
  logic [31:0]      w_key;
  logic             w_take;
  logic             w_close;
  logic             w_len_err;
  logic             w_fin_have;
  logic [31:0]      w_fin_key;
  logic [IDX_W-1:0] w_fin_idx;
  logic [31:0]      w_fin_val;
  logic [31:0]      w_word0;

  assign w_in_beat  = INPUT_AXIS_TVALID && r_in_ready;
  assign w_out_beat = r_out_valid && OUTPUT_AXIS_TREADY;

  always_comb begin
    w_nan = (INPUT_AXIS_TDATA[30:23] == 8'hFF) && (INPUT_AXIS_TDATA[22:0] != 23'd0);
    // Negative numbers invert fully, positives flip the sign bit: the result
    // orders as unsigned, with +0 above -0.
    w_key = INPUT_AXIS_TDATA[31] ? ~INPUT_AXIS_TDATA : (INPUT_AXIS_TDATA ^ 32'h8000_0000);
    // Strictly greater keeps the earliest index on ties.
    w_take = !w_nan && (!r_have || (w_key > r_best_key));

    w_fin_have = r_have || !w_nan;
    w_fin_key  = w_take ? w_key            : r_best_key;
    w_fin_idx  = w_take ? r_count          : r_best_idx;
    w_fin_val  = w_take ? INPUT_AXIS_TDATA : r_best_val;

    w_close   = INPUT_AXIS_TLAST || (r_count == LAST_IX);
    // Short frame (TLAST early) or full-length frame without TLAST.
    w_len_err = INPUT_AXIS_TLAST ^ (r_count == LAST_IX);

    w_word0              = '0;
    w_word0[31]          = w_len_err;
    w_word0[30]          = !w_fin_have;
    w_word0[IDX_W-1:0]   = w_fin_have ? w_fin_idx : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_ACCUM;
      r_count     <= '0;
      r_best_key  <= '0;
      r_best_idx  <= '0;
      r_best_val  <= '0;
      r_have      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_in_beat) begin
            r_count    <= r_count + 1'b1;
            r_have     <= w_fin_have;
            r_best_key <= w_fin_key;
            r_best_idx <= w_fin_idx;
            r_best_val <= w_fin_val;
            if (w_close) begin
              // Park word1 in r_best_val; input stalls until the pair drains.
              r_best_val  <= w_fin_have ? w_fin_val : QNAN;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_last  <= 1'b0;
              r_out_data  <= w_word0;
              r_state     <= S_IDX;
            end
          end
        end
        S_IDX: begin
          if (w_out_beat) begin
            r_out_data <= r_best_val;
            r_out_last <= 1'b1;
            r_state    <= S_VAL;
          end
        end
        S_VAL: begin
          if (w_out_beat) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_count     <= '0;
            r_best_key  <= '0;
            r_best_idx  <= '0;
            r_best_val  <= '0;
            r_have      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_ACCUM;
          end
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  assign INPUT_AXIS_TREADY  = r_in_ready;
  assign OUTPUT_AXIS_TVALID = r_out_valid;
  assign OUTPUT_AXIS_TLAST  = r_out_last;
  assign OUTPUT_AXIS_TDATA  = r_out_data;

endmodule

// File: tb/tb_argmax_stream.sv
// Scoreboard bench for argmax_stream: expected result words are queued as
// each frame is driven and popped when the DUT completes an output beat.
module tb_argmax_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_chk = 0;
  int n_err = 0;
  logic [32:0] sb_q[$];  // {tlast, tdata}

  always #5 clk = ~clk;

  argmax_stream #(.LEN(4), .IDX_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .INPUT_AXIS_TDATA  (in_data),
    .INPUT_AXIS_TLAST  (in_last),
    .INPUT_AXIS_TVALID (in_valid),
    .INPUT_AXIS_TREADY (in_ready),
    .OUTPUT_AXIS_TDATA (out_data),
    .OUTPUT_AXIS_TLAST (out_last),
    .OUTPUT_AXIS_TVALID(out_valid),
    .OUTPUT_AXIS_TREADY(out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Output monitor: a beat fires on the next posedge when valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out", {31'd0, out_last, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("out_word", {31'd0, out_last, out_data}, {31'd0, e});
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int t;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_pair(input logic [31:0] w0, input logic [31:0] w1);
    sb_q.push_back({1'b0, w0});
    sb_q.push_back({1'b1, w1});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_tready", {63'd0, in_ready}, 64'd0);
    chk("rst_outs", {30'd0, out_valid, out_last, out_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("tready_pre", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("tready_rise", {63'd0, in_ready}, 64'd1);

    // Ascending positives
    expect_pair(32'h0000_0003, 32'h40B3_3334);
    send(32'h4073_3334, 0); send(32'h408C_CCCD, 0);
    send(32'h40A0_0000, 0); send(32'h40B3_3334, 1);
    drain();

    // Negatives, tie keeps earliest
    expect_pair(32'h0000_0001, 32'hBF00_0000);
    send(32'hBF80_0000, 0); send(32'hBF00_0000, 0);
    send(32'hC000_0000, 0); send(32'hBF00_0000, 1);
    // Signed zeros plus NaN, back to back with previous frame
    expect_pair(32'h0000_0001, 32'h0000_0000);
    send(32'h8000_0000, 0); send(32'h0000_0000, 0);
    send(32'hC040_0000, 0); send(32'h7FC0_0000, 1);
    drain();

    // All NaN
    expect_pair(32'h4000_0000, 32'h7FC0_0000);
    for (int i = 0; i < 4; i++) send(32'h7FC0_0001, i == 3);
    drain();

    // +inf beats finite values, NaN-free mixed signs
    expect_pair(32'h0000_0003, 32'h7F80_0000);
    send(32'hC0A0_0000, 0); send(32'h40E0_0000, 0);
    send(32'h40E0_0000, 0); send(32'h7F80_0000, 1);
    drain();

    // Backpressure: word0 must hold for 10 cycles, input stalled
    out_ready = 1'b0;
    expect_pair(32'h0000_0002, 32'h40A0_0000);
    send(32'h3F80_0000, 0); send(32'h4000_0000, 0);
    send(32'h40A0_0000, 0); send(32'h4040_0000, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {29'd0, out_valid, out_last, in_ready, out_data},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0002});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Short frame, then full frame without TLAST
    expect_pair(32'h8000_0001, 32'h4000_0000);
    send(32'h3F80_0000, 0); send(32'h4000_0000, 1);
    expect_pair(32'h8000_0000, 32'h4080_0000);
    send(32'h4080_0000, 0); send(32'h4040_0000, 0);
    send(32'h4000_0000, 0); send(32'h3F80_0000, 0);
    drain();

    // Single-word frame
    expect_pair(32'h8000_0000, 32'hC040_0000);
    send(32'hC040_0000, 1);
    drain();

    // Reset mid-frame discards the partial frame
    send(32'h4100_0000, 0); send(32'h4110_0000, 0);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {29'd0, in_ready, out_valid, out_last, out_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_pair(32'h0000_0003, 32'h40B3_3334);
    send(32'h4073_3334, 0); send(32'h408C_CCCD, 0);
    send(32'h40A0_0000, 0); send(32'h40B3_3334, 1);
    drain();

    repeat (5) @(posedge clk);
    #1;
    chk("idle_valid", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
